// File: rtl/mem_access_unit.sv
// MIPS32 MEM-stage load/store controller over a word-wide memory without byte enables.
// Define MAU_ALIGN_CHECK_EN to flag misaligned halfword/word accesses instead of forcing alignment.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [OP_W-1:0] OP_LB  = 3'd0;
  localparam logic [OP_W-1:0] OP_LBU = 3'd1;
  localparam logic [OP_W-1:0] OP_LH  = 3'd2;
  localparam logic [OP_W-1:0] OP_LHU = 3'd3;
  localparam logic [OP_W-1:0] OP_LW  = 3'd4;
  localparam logic [OP_W-1:0] OP_SB  = 3'd5;
  localparam logic [OP_W-1:0] OP_SH  = 3'd6;
  localparam logic [OP_W-1:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [HALF_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                misalign_c;
  logic [ADDR_W-1:0]   addr_fix_c;

  // Little-endian lane extraction with sign/zero extension.
  function automatic logic [DATA_W-1:0] load_extract(input logic [OP_W-1:0]   op,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [DATA_W-1:0] word);
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;
    logic [DATA_W-1:0] r;
    b = BYTE_W'(word >> {off, 3'b000});
    h = off[1] ? word[HALF_W +: HALF_W] : word[0 +: HALF_W];
    case (op)
      OP_LB:   r = {{(DATA_W-BYTE_W){b[BYTE_W-1]}}, b};
      OP_LBU:  r = {{(DATA_W-BYTE_W){1'b0}}, b};
      OP_LH:   r = {{(DATA_W-HALF_W){h[HALF_W-1]}}, h};
      OP_LHU:  r = {{(DATA_W-HALF_W){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace one byte or halfword lane of the read word, keeping the rest.
  function automatic logic [DATA_W-1:0] store_merge(input logic [OP_W-1:0]   op,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [DATA_W-1:0] word,
                                                    input logic [HALF_W-1:0] wd);
    logic [DATA_W-1:0] w;
    w = word;
    if (op == OP_SB) begin
      w[{off, 3'b000} +: BYTE_W] = wd[BYTE_W-1:0];
    end else begin
      w[{off[1], 4'b0000} +: HALF_W] = wd;
    end
    return w;
  endfunction

  // Alignment handling: either flag the request or silently clear the low address bits.
  always_comb begin
    addr_fix_c = req_addr;
    misalign_c = 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
    case (req_op)
      OP_LH, OP_LHU, OP_SH: misalign_c = req_addr[0];
      OP_LW, OP_SW:         misalign_c = |req_addr[1:0];
      default:              misalign_c = 1'b0;
    endcase
`else
    case (req_op)
      OP_LH, OP_LHU, OP_SH: addr_fix_c[0]   = 1'b0;
      OP_LW, OP_SW:         addr_fix_c[1:0] = 2'b00;
      default:              addr_fix_c      = req_addr;
    endcase
`endif
  end

  // Next-state and next-output logic; outputs are registered from the state being entered.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d         = req_op;
          off_d        = addr_fix_c[OFF_W-1:0];
          wdata_d      = req_wdata[HALF_W-1:0];
          mem_addr_d   = {addr_fix_c[ADDR_W-1:OFF_W], 2'b00};
          req_ready_d  = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (misalign_c) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_op == OP_SW) begin
            state_d     = S_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        resp_err_d = resp_err_q | mem_err;
        if ((op_q == OP_SB) || (op_q == OP_SH)) begin
          state_d     = S_WR;
          mem_we_d    = 1'b1;
          mem_wdata_d = store_merge(op_q, off_q, mem_rdata, wdata_q);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extract(op_q, off_q, mem_rdata);
        end
      end

      S_WR: begin
        resp_err_d   = resp_err_q | mem_err;
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a byte-level reference memory model.
// Expectations follow MAU_ALIGN_CHECK_EN when the build defines it.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_words [0:255];
  logic [7:0]  ref_bytes [0:1023];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_val;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  // 1 KiB word memory: combinational read, clocked write, backdoor port for setup.
  assign mem_rdata = mem_words[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem_words[mem_addr[9:2]] <= mem_wdata;
    else if (bd_we) mem_words[bd_idx] <= bd_val;
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'({a[9:2], 2'b00});
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = a[9:2]; bd_val = v;
    @(posedge clk);
    #1 bd_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_bytes[int'({a[9:2], 2'b00}) + i] = 8'(v >> (8 * i));
  endtask

  // Reference: what the request should return, how long it takes and whether it writes.
  task automatic model_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic err_inj, output logic [31:0] rd, output logic err,
                           output int lat, output int we_mask, output logic [31:0] maddr);
    logic [31:0] a;
    logic        mis;
    int          size;
    logic [31:0] v;
    a = addr; mis = 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
    if ((op == 3'd2 || op == 3'd3 || op == 3'd6) && a[0]) mis = 1'b1;
    if ((op == 3'd4 || op == 3'd7) && (a[1:0] != 2'b00)) mis = 1'b1;
`else
    if (op == 3'd2 || op == 3'd3 || op == 3'd6) a[0] = 1'b0;
    if (op == 3'd4 || op == 3'd7) a[1:0] = 2'b00;
`endif
    maddr = {a[31:2], 2'b00};
    rd = 32'h0; err = err_inj; we_mask = 0;
    if (mis) begin
      err = 1'b1; lat = 1;
      return;
    end
    case (op)
      3'd0, 3'd1, 3'd5: size = 1;
      3'd2, 3'd3, 3'd6: size = 2;
      default:          size = 4;
    endcase
    if (op <= 3'd4) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[int'(a[9:0]) + i]) << (8 * i));
      if (op == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v; lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[int'(a[9:0]) + i] = 8'(wd >> (8 * i));
      lat     = (op == 3'd7) ? 2 : 3;
      we_mask = 1 << (lat - 2);
    end
  endtask

  // Drive one request, observe the response cycle by cycle, then complete the handshake.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat,
                         output int we_mask, output logic [31:0] maddr, output logic tmo);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; we_mask = 0; tmo = 1'b0; rd = 32'h0; err = 1'b0; maddr = 32'h0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_we) we_mask = we_mask | (1 << (lat - 1));
    end while (!resp_valid && lat < 20);
    if (!resp_valid) tmo = 1'b1;
    rd = resp_rdata; err = resp_err; maddr = mem_addr;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
  endtask

  task automatic test_loads();
    logic [2:0]  ops [4];
    logic [31:0] adr [4];
    logic [31:0] exp [4];
    logic [31:0] rd, ma;
    logic        err, tmo;
    int          lat, wm;
    ops = '{3'd0, 3'd1, 3'd2, 3'd4};
    adr = '{32'h100, 32'h100, 32'h102, 32'h100};
    exp = '{32'hFFFF_FFA1, 32'h0000_00A1, 32'hFFFF_8765, 32'h8765_43A1};
    set_word(32'h100, 32'h8765_43A1);
    for (int i = 0; i < 4; i++) begin
      run_req(ops[i], adr[i], 32'h0, rd, err, lat, wm, ma, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL load%0d_timeout: no resp_valid within 20 cycles", i); end
      checks++; if (rd !== exp[i]) begin errors++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, exp[i]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL load%0d_err: got %b want 0", i, err); end
      checks++; if (lat != 2) begin errors++; $display("FAIL load%0d_latency: got %0d want 2", i, lat); end
      checks++; if (wm != 0) begin errors++; $display("FAIL load%0d_we: got mask %0d want 0", i, wm); end
    end
  endtask

  task automatic test_sub_stores();
    logic [31:0] rd, ma, mrd, mma;
    logic        err, tmo, merr;
    int          lat, wm, mlat, mwm;
    set_word(32'h200, 32'h1122_3344);
    model_req(3'd5, 32'h201, 32'hAA, 1'b0, mrd, merr, mlat, mwm, mma);
    run_req(3'd5, 32'h201, 32'hAA, rd, err, lat, wm, ma, tmo);
    checks++; if (lat != 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", lat); end
    checks++; if (wm != 2) begin errors++; $display("FAIL sb_we_mask: got %0d want 2", wm); end
    checks++; if (ma !== 32'h200) begin errors++; $display("FAIL sb_mem_addr: got %h want 00000200", ma); end
    checks++; if (mem_words[8'h80] !== 32'h1122_AA44) begin errors++; $display("FAIL sb_mem_word: got %h want 1122aa44", mem_words[8'h80]); end
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL sb_resp: got rdata %h err %b want 0/0", rd, err); end
    model_req(3'd6, 32'h202, 32'hBEEF, 1'b0, mrd, merr, mlat, mwm, mma);
    run_req(3'd6, 32'h202, 32'hBEEF, rd, err, lat, wm, ma, tmo);
    checks++; if (lat != 3) begin errors++; $display("FAIL sh_latency: got %0d want 3", lat); end
    checks++; if (wm != 2) begin errors++; $display("FAIL sh_we_mask: got %0d want 2", wm); end
    checks++; if (mem_words[8'h80] !== 32'hBEEF_AA44) begin errors++; $display("FAIL sh_mem_word: got %h want beefaa44", mem_words[8'h80]); end
  endtask

  task automatic test_sw();
    logic [31:0] rd, ma, mrd, mma;
    logic        err, tmo, merr;
    int          lat, wm, mlat, mwm;
    model_req(3'd7, 32'h300, 32'hDEAD_BEEF, 1'b0, mrd, merr, mlat, mwm, mma);
    run_req(3'd7, 32'h300, 32'hDEAD_BEEF, rd, err, lat, wm, ma, tmo);
    checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (wm != 1) begin errors++; $display("FAIL sw_we_mask: got %0d want 1", wm); end
    checks++; if (mem_words[8'hC0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_mem_word: got %h want deadbeef", mem_words[8'hC0]); end
    run_req(3'd4, 32'h300, 32'h0, rd, err, lat, wm, ma, tmo);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_readback: got %h want deadbeef", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, ma, mrd, mma;
    logic        err, tmo, merr;
    int          lat, wm, mlat, mwm;
    set_word(32'h100, 32'h8765_43A1);
`ifdef MAU_ALIGN_CHECK_EN
    run_req(3'd4, 32'h102, 32'h0, rd, err, lat, wm, ma, tmo);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_lw_err: got %b want 1", err); end
    checks++; if (lat != 1) begin errors++; $display("FAIL mis_lw_latency: got %0d want 1", lat); end
    checks++; if (wm != 0) begin errors++; $display("FAIL mis_lw_we: got mask %0d want 0", wm); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_lw_rdata: got %h want 0", rd); end
`else
    run_req(3'd4, 32'h102, 32'h0, rd, err, lat, wm, ma, tmo);
    checks++; if (rd !== 32'h8765_43A1) begin errors++; $display("FAIL mis_lw_rdata: got %h want 876543a1", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_lw_err: got %b want 0", err); end
    checks++; if (lat != 2) begin errors++; $display("FAIL mis_lw_latency: got %0d want 2", lat); end
`endif
    model_req(3'd6, 32'h103, 32'h1234, 1'b0, mrd, merr, mlat, mwm, mma);
    run_req(3'd6, 32'h103, 32'h1234, rd, err, lat, wm, ma, tmo);
    checks++; if (err !== merr || lat != mlat || wm != mwm) begin
      errors++; $display("FAIL mis_sh: got err %b lat %0d we %0d want %b %0d %0d", err, lat, wm, merr, mlat, mwm);
    end
    checks++; if (mem_words[8'h40] !== ref_word(32'h100)) begin errors++; $display("FAIL mis_sh_mem: got %h want %h", mem_words[8'h40], ref_word(32'h100)); end
  endtask

  task automatic test_mem_err();
    logic [31:0] rd, ma, mrd, mma;
    logic        err, tmo, merr;
    int          lat, wm, mlat, mwm;
    mem_err = 1'b1;
    run_req(3'd4, 32'h300, 32'h0, rd, err, lat, wm, ma, tmo);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL memerr_lw: got err %b want 1", err); end
    model_req(3'd5, 32'h304, 32'h5A, 1'b1, mrd, merr, mlat, mwm, mma);
    run_req(3'd5, 32'h304, 32'h5A, rd, err, lat, wm, ma, tmo);
    checks++; if (err !== 1'b1 || lat != 3) begin errors++; $display("FAIL memerr_sb: got err %b lat %0d want 1 3", err, lat); end
    mem_err = 1'b0;
    run_req(3'd4, 32'h300, 32'h0, rd, err, lat, wm, ma, tmo);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL memerr_clear: got err %b want 0", err); end
  endtask

  task automatic test_stall();
    logic [31:0] first, mrd, mma, a1, a2;
    logic        merr;
    int          n, mlat, mwm;
    a1 = {22'h0, 8'($urandom), 2'b00};
    a2 = {22'h0, 8'($urandom), 2'b00};
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_addr = a1; req_wdata = 32'h0; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    checks++; if (!resp_valid) begin errors++; $display("FAIL stall_timeout: no resp_valid within 20 cycles"); end
    first = resp_rdata;
    model_req(3'd4, a1, 32'h0, 1'b0, mrd, merr, mlat, mwm, mma);
    checks++; if (first !== mrd) begin errors++; $display("FAIL stall_rdata: got %h want %h", first, mrd); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== first || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got valid %b rdata %h ready %b want 1 %h 0", i, resp_valid, resp_rdata, req_ready, first);
      end
    end
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'd4; req_addr = a2;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got ready %b valid %b want 1 0", req_ready, resp_valid);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_next_accept: got ready %b want 0", req_ready); end
    n = 1;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    model_req(3'd4, a2, 32'h0, 1'b0, mrd, merr, mlat, mwm, mma);
    checks++; if (resp_rdata !== mrd || n != 2) begin errors++; $display("FAIL stall_next_resp: got %h lat %0d want %h 2", resp_rdata, n, mrd); end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wr();
    logic [31:0] rd, ma;
    logic        err, tmo;
    int          lat, wm, n;
    set_word(32'h204, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h205; req_wdata = 32'h55; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_we && n < 10);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_wr_reach: got mem_we %b want 1", mem_we); end
    reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_wr_ctrl: got we %b valid %b ready %b want 0 0 1", mem_we, resp_valid, req_ready);
    end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL rst_wr_data: got addr %h wdata %h rdata %h err %b want zeros", mem_addr, mem_wdata, resp_rdata, resp_err);
    end
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    checks++; if (mem_words[8'h81] !== ref_word(32'h204)) begin errors++; $display("FAIL rst_wr_mem: got %h want %h", mem_words[8'h81], ref_word(32'h204)); end
    run_req(3'd4, 32'h204, 32'h0, rd, err, lat, wm, ma, tmo);
    checks++; if (rd !== 32'hCAFE_F00D || lat != 2) begin errors++; $display("FAIL rst_wr_after: got %h lat %0d want cafef00d 2", rd, lat); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] addr, wd, rd, ma, mrd, mma;
    logic        err, tmo, merr, ei;
    int          lat, wm, mlat, mwm;
    for (int k = 0; k < 200; k++) begin
      op = 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom;
      ei = ($urandom_range(0, 7) == 0);
      mem_err = ei;
      model_req(op, addr, wd, ei, mrd, merr, mlat, mwm, mma);
      run_req(op, addr, wd, rd, err, lat, wm, ma, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rnd%0d_timeout: op %0d no resp_valid", k, op); end
      checks++; if (rd !== mrd) begin errors++; $display("FAIL rnd%0d_rdata: op %0d addr %h got %h want %h", k, op, addr, rd, mrd); end
      checks++; if (err !== merr) begin errors++; $display("FAIL rnd%0d_err: op %0d addr %h got %b want %b", k, op, addr, err, merr); end
      checks++; if (lat != mlat || wm != mwm) begin
        errors++; $display("FAIL rnd%0d_timing: op %0d got lat %0d we %0d want %0d %0d", k, op, lat, wm, mlat, mwm);
      end
      checks++; if (ma !== mma) begin errors++; $display("FAIL rnd%0d_mem_addr: got %h want %h", k, ma, mma); end
    end
    mem_err = 1'b0;
    for (int i = 0; i < 256; i++) begin
      checks++; if (mem_words[i] !== ref_word(32'(i) << 2)) begin
        errors++; $display("FAIL final_mem%0d: got %h want %h", i, mem_words[i], ref_word(32'(i) << 2));
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0; mem_err = 1'b0; bd_we = 1'b0; bd_idx = 8'h0; bd_val = 32'h0;
    test_reset();
    for (int i = 0; i < 256; i++) set_word(32'(i) << 2, $urandom);
    test_loads();
    test_sub_stores();
    test_sw();
    test_misalign();
    test_mem_err();
    test_stall();
    test_reset_mid_wr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
